// File: rtl/stopuhr_core.sv
`default_nettype none
// ============================================================================
// Module   : stopuhr_core
// Summary  : Stopwatch engine (4-state FSM, BCD time counter) with a
//            multiplexed common-anode 7-segment scan driver.
//            Optional lap-hold display snapshot when STOPUHR_LAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module stopuhr_core #(
    parameter int TICK_DIV = 5000000,
    parameter int DIGITS   = 4,
    parameter int MUX_DIV  = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  clr,
    input  logic                  lap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     pos,
    output logic                  running,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_MW-1:0] c_SCAN_MAX  = c_MW'(MUX_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_MAX   = c_IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_STOPPED = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_btn_cur;
    logic [3:0]             r_btn_prev;
    logic [3:0]             w_evt;
    logic                   w_evt_start;
    logic                   w_evt_pause;
    logic                   w_evt_stop;
    logic                   w_evt_clr;
    logic                   w_tick;
    logic [c_PW-1:0]        r_presc;
    logic [4*DIGITS-1:0]    r_digits;
    logic [4*DIGITS-1:0]    w_digits_inc;
    logic [4*DIGITS-1:0]    w_disp;
    logic [3:0]             w_disp_digit;
    logic [c_MW-1:0]        r_scan_cnt;
    logic [c_IW-1:0]        r_scan_idx;

    // Bit order: [0] start, [1] pause, [2] stop, [3] clr
    assign w_evt       = r_btn_cur & ~r_btn_prev;
    assign w_evt_start = w_evt[0];
    assign w_evt_pause = w_evt[1];
    assign w_evt_stop  = w_evt[2];
    assign w_evt_clr   = w_evt[3];

    assign w_tick  = (r_state == S_RUN) && (r_presc == c_PRESC_MAX);
    assign running = (r_state == S_RUN);
    assign bcd     = r_digits;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_cur  <= 4'b0;
            r_btn_prev <= 4'b0;
        end else begin
            r_btn_cur  <= {clr, stop, pause, start};
            r_btn_prev <= r_btn_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Only the highest-priority event present is acted upon.
    always_comb begin
        w_state_next = r_state;
        if (w_evt_clr) begin
            w_state_next = S_IDLE;
        end else if (w_evt_stop) begin
            if (r_state == S_RUN) begin
                w_state_next = S_STOPPED;
            end
        end else if (w_evt_pause) begin
            if (r_state == S_RUN) begin
                w_state_next = S_PAUSED;
            end else if (r_state == S_PAUSED) begin
                w_state_next = S_RUN;
            end
        end else if (w_evt_start) begin
            if ((r_state == S_IDLE) || (r_state == S_PAUSED)) begin
                w_state_next = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_evt_clr) begin
            r_presc <= '0;
        end else if (r_state == S_RUN) begin
            r_presc <= w_tick ? '0 : (r_presc + c_PW'(1));
        end
    end

    // Ripple carry: digit 2 (tens of seconds) rolls over at 5, others at 9.
    always_comb begin : p_inc
        logic v_carry;
        v_carry      = 1'b1;
        w_digits_inc = r_digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (v_carry) begin
                if (r_digits[4*i +: 4] == ((i == 2) ? 4'd5 : 4'd9)) begin
                    w_digits_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_digits_inc[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
                    v_carry                = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_evt_clr) begin
            r_digits <= '0;
        end else if (w_tick) begin
            r_digits <= w_digits_inc;
        end
    end

`ifdef STOPUHR_LAP_EN
    logic                r_lap_cur;
    logic                r_lap_prev;
    logic                r_hold;
    logic [4*DIGITS-1:0] r_snap;
    logic                w_lap_toggle;

    assign w_lap_toggle = r_lap_cur && !r_lap_prev
                       && !(w_evt_clr || w_evt_stop || w_evt_pause || w_evt_start)
                       && ((r_state == S_RUN) || (r_state == S_PAUSED));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lap_cur  <= 1'b0;
            r_lap_prev <= 1'b0;
            r_hold     <= 1'b0;
            r_snap     <= '0;
        end else begin
            r_lap_cur  <= lap;
            r_lap_prev <= r_lap_cur;
            if ((w_state_next == S_STOPPED) || (w_state_next == S_IDLE)) begin
                r_hold <= 1'b0;
            end else if (w_lap_toggle) begin
                r_hold <= !r_hold;
                if (!r_hold) begin
                    r_snap <= r_digits;
                end
            end
        end
    end

    assign w_disp = r_hold ? r_snap : r_digits;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign w_disp       = r_digits;
`endif

    always_comb begin
        w_disp_digit = w_disp[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan_idx == c_IW'(i)) begin
                w_disp_digit = w_disp[4*i +: 4];
            end
        end
    end

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            pos        <= '1;
            seg        <= 7'h7F;
        end else begin
            pos <= ~({{(DIGITS-1){1'b0}}, 1'b1} << r_scan_idx);
            seg <= f_seg(w_disp_digit);
            if (r_scan_cnt == c_SCAN_MAX) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == c_IDX_MAX) ? '0 : (r_scan_idx + c_IW'(1));
            end else begin
                r_scan_cnt <= r_scan_cnt + c_MW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopuhr_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopuhr_core
// Summary  : Self-checking bench for stopuhr_core with a tenths-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopuhr_core;

    localparam int TICK_DIV = 4;
    localparam int DIGITS   = 4;
    localparam int MUX_DIV  = 2;
    localparam int MOD      = 600 * (10 ** (DIGITS - 3));
`ifdef STOPUHR_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_STOPPED = 3;

    logic                clk = 1'b0;
    logic                reset, start, pause, stop, clr, lap;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   pos;
    logic                running;
    logic [4*DIGITS-1:0] bcd;

    int checks   = 0;
    int failures = 0;

    stopuhr_core #(.TICK_DIV(TICK_DIV), .DIGITS(DIGITS), .MUX_DIV(MUX_DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .clr(clr), .lap(lap), .seg(seg), .pos(pos), .running(running), .bcd(bcd)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed time kept as a plain count of tenths.
    int                m_st, m_presc, m_tenths, m_snap, m_scnt, m_sidx;
    bit                m_hold;
    bit [4:0]          m_cur, m_prev;
    logic [DIGITS-1:0] m_pos;
    logic [6:0]        m_seg;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int t);
        logic [4*DIGITS-1:0] r;
        int m;
        r[3:0]  = 4'(t % 10);
        r[7:4]  = 4'((t / 10) % 10);
        r[11:8] = 4'((t / 100) % 6);
        m = t / 600;
        for (int i = 3; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] lit;
        case (d)
            4'd0: lit = 7'h3F;  4'd1: lit = 7'h06;  4'd2: lit = 7'h5B;
            4'd3: lit = 7'h4F;  4'd4: lit = 7'h66;  4'd5: lit = 7'h6D;
            4'd6: lit = 7'h7D;  4'd7: lit = 7'h07;  4'd8: lit = 7'h7F;
            4'd9: lit = 7'h6F;  default: lit = 7'h00;
        endcase
        return ~lit;
    endfunction

    function automatic logic [4*DIGITS+11:0] exp_vec();
        return {(m_st == M_RUN), m_pos, m_seg, to_bcd(m_tenths)};
    endfunction

    task automatic model_step();
        bit [4:0]            ev;
        int                  old_t;
        bit                  tk;
        logic [4*DIGITS-1:0] dv;
        if (reset) begin
            m_st = M_IDLE; m_presc = 0; m_tenths = 0; m_hold = 0; m_snap = 0;
            m_scnt = 0; m_sidx = 0; m_pos = '1; m_seg = 7'h7F; m_cur = 0; m_prev = 0;
            return;
        end
        ev     = m_cur & ~m_prev;
        m_prev = m_cur;
        m_cur  = {lap, clr, stop, pause, start};
        dv     = to_bcd(m_hold ? m_snap : m_tenths);
        m_seg  = glyph(dv[4*m_sidx +: 4]);
        m_pos  = ~(DIGITS'(1) << m_sidx);
        if (m_scnt == MUX_DIV - 1) begin
            m_scnt = 0;
            m_sidx = (m_sidx + 1) % DIGITS;
        end else begin
            m_scnt++;
        end
        old_t = m_tenths;
        if (ev[3]) begin
            m_st = M_IDLE; m_presc = 0; m_tenths = 0; m_hold = 0;
        end else begin
            tk = (m_st == M_RUN) && (m_presc == TICK_DIV - 1);
            if (m_st == M_RUN) begin
                if (tk) begin
                    m_presc  = 0;
                    m_tenths = (m_tenths + 1) % MOD;
                end else begin
                    m_presc++;
                end
            end
            if (ev[2]) begin
                if (m_st == M_RUN) begin
                    m_st = M_STOPPED; m_hold = 0;
                end
            end else if (ev[1]) begin
                if (m_st == M_RUN) m_st = M_PAUSED;
                else if (m_st == M_PAUSED) m_st = M_RUN;
            end else if (ev[0]) begin
                if (m_st == M_IDLE || m_st == M_PAUSED) m_st = M_RUN;
            end else if (ev[4] && LAP_EN && (m_st == M_RUN || m_st == M_PAUSED)) begin
                if (m_hold) begin
                    m_hold = 0;
                end else begin
                    m_hold = 1; m_snap = old_t;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; pause = 0; stop = 0; clr = 0; lap = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== {1'b0, {DIGITS{1'b1}}, 7'h7F, {(4*DIGITS){1'b0}}}) begin
                failures++;
                $display("FAIL reset_state: got run=%b pos=%h seg=%h bcd=%h, want 0/f/7f/0",
                         running, pos, seg, bcd);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL post_reset: got %h want %h", {running, pos, seg, bcd}, exp_vec());
            end
        end
    endtask

    task automatic test_start();
        bit done = 0;
        start = 1; cyc(); start = 0; cyc();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL start_latency: running got %b want 1", running);
        end
        for (int i = 0; i < 40; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL start_run: got %h want %h", {running, pos, seg, bcd}, exp_vec());
            end
        end
        checks++;
        if (bcd !== 16'h0010) begin
            failures++;
            $display("FAIL one_second: bcd got %h want 0010", bcd);
        end
        for (int i = 0; i < 1000 && !done; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec() || bcd[11:8] > 4'd5) begin
                failures++;
                $display("FAIL run_to_100: got %h want %h", {running, pos, seg, bcd}, exp_vec());
            end
            if (bcd == 16'h0100) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL run_to_100_timeout: bcd got %h want 0100", bcd);
        end
    endtask

    task automatic test_pause();
        bit done = 0;
        int res, n;
        clr = 1; cyc(); clr = 0; cyc();
        start = 1; cyc(); start = 0; cyc();
        for (int i = 0; i < 500 && !done; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL run_to_35: got %h want %h", {running, pos, seg, bcd}, exp_vec());
            end
            if (bcd == 16'h0035) done = 1;
        end
        pause = 1; cyc(); pause = 0; cyc();
        res = m_presc;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (bcd !== 16'h0035 || {running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL pause_hold: got %h want bcd 0035 vec %h", {running, pos, seg, bcd}, exp_vec());
            end
        end
        pause = 1; cyc(); pause = 0; cyc();
        n = 0;
        for (int i = 0; i < 2 * TICK_DIV && bcd == 16'h0035; i++) begin
            cyc();
            n++;
        end
        checks++;
        if (n != TICK_DIV - res || bcd !== 16'h0036) begin
            failures++;
            $display("FAIL resume_residue: got %0d cycles bcd %h want %0d cycles bcd 0036",
                     n, bcd, TICK_DIV - res);
        end
    endtask

    task automatic test_clr_priority();
        start = 1; pause = 1; clr = 1; cyc();
        start = 0; pause = 0; clr = 0; cyc();
        checks++;
        if (running !== 1'b0 || bcd !== 16'h0000 || {running, pos, seg, bcd} !== exp_vec()) begin
            failures++;
            $display("FAIL clr_priority: got run=%b bcd=%h want 0/0000", running, bcd);
        end
        stop = 1; cyc(); stop = 0;
        for (int i = 0; i < 4; i++) cyc();
        checks++;
        if (running !== 1'b0 || bcd !== 16'h0000) begin
            failures++;
            $display("FAIL stop_in_idle: got run=%b bcd=%h want 0/0000", running, bcd);
        end
        start = 1; cyc(); start = 0; cyc();
        checks++;
        if (running !== 1'b1 || {running, pos, seg, bcd} !== exp_vec()) begin
            failures++;
            $display("FAIL restart: running got %b want 1", running);
        end
    endtask

    task automatic test_wrap();
        bit done = 0;
        logic [DIGITS-1:0] prev_pos;
        logic [DIGITS-1:0] seq [8];
        seq = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
        for (int i = 0; i < 30000 && !done; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL run_to_wrap: got %h want %h", {running, pos, seg, bcd}, exp_vec());
            end
            if (bcd == 16'h9599) done = 1;
        end
        for (int i = 0; i < 2 * TICK_DIV && bcd == 16'h9599; i++) cyc();
        checks++;
        if (bcd !== 16'h0000 || running !== 1'b1) begin
            failures++;
            $display("FAIL wrap: got bcd=%h run=%b want 0000/1", bcd, running);
        end
        done = 0;
        for (int i = 0; i < 4 * DIGITS * MUX_DIV && !done; i++) begin
            prev_pos = pos;
            cyc();
            if (pos == 4'hE && prev_pos != 4'hE) done = 1;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pos !== seq[i]) begin
                failures++;
                $display("FAIL pos_sequence[%0d]: got %h want %h", i, pos, seq[i]);
            end
            cyc();
        end
    endtask

    task automatic test_lap();
        bit done = 0;
        int k;
        logic [15:0] snapv;
        snapv = 16'h0012;
        clr = 1; cyc(); clr = 0; cyc();
        start = 1; cyc(); start = 0; cyc();
        for (int i = 0; i < 200 && !done; i++) begin
            cyc();
            if (bcd == 16'h0012) done = 1;
        end
        lap = 1; cyc(); lap = 0; cyc();
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL lap_hold: got %h want %h", {running, pos, seg, bcd}, exp_vec());
            end
`ifdef STOPUHR_LAP_EN
            k = 0;
            for (int j = 0; j < DIGITS; j++) if (pos[j] == 1'b0) k = j;
            checks++;
            if (seg !== glyph(snapv[4*k +: 4])) begin
                failures++;
                $display("FAIL lap_snapshot_digit%0d: seg got %h want %h", k, seg, glyph(snapv[4*k +: 4]));
            end
`endif
        end
        checks++;
        if (bcd !== 16'h0014) begin
            failures++;
            $display("FAIL lap_counting: bcd got %h want 0014", bcd);
        end
        lap = 1; cyc(); lap = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL lap_release: got %h want %h", {running, pos, seg, bcd}, exp_vec());
            end
        end
        lap = 1; cyc(); lap = 0; cyc(); cyc(); cyc();
        stop = 1; cyc(); stop = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL lap_stop_release: got %h want %h", {running, pos, seg, bcd}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int r;
        clr = 1; cyc(); clr = 0; cyc();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                case ($urandom_range(0, 3))
                    0: start = ~start;
                    1: pause = ~pause;
                    2: stop  = ~stop;
                    default: lap = ~lap;
                endcase
            end else if (r == 8) begin
                clr = ~clr;
            end
            cyc();
            checks++;
            if ({running, pos, seg, bcd} !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d]: got %h want %h", i, {running, pos, seg, bcd}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_clr_priority();
        test_wrap();
        test_lap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
